kbd_matrix_combo: RTL and testbench

- Parametrised successor to the QL keyboard matrix block: holds an R×C key matrix, fed by pre-decoded key events from the PS/2 front end.
- Adds N programmable combo channels; each drives a modifier bit, then the main bit after a programmable lead delay.
- Guarantees a minimum main-key hold, so short taps are never lost.
- Uses a synchronous tick prescaler (no derived clock) and offers a registered row-scan read port for the IPC model.

---
 rtl/kbd_matrix_combo.sv | 180 ++++++++++++++++++
 tb/tb_kbd_matrix_combo.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_matrix_combo.sv
// Key matrix fed by toggle-signalled key events, with programmable combo channels that
// hold a modifier key, assert a main key after a lead delay and keep it up a minimum time.
module kbd_matrix_combo #(
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int NUM_COMBO  = 12,
    parameter int PRESCALE   = 1024,
    parameter int LEAD_TICKS = 15,
    parameter int MIN_HOLD   = 4,
    localparam int NKEYS = ROWS * COLS,
    localparam int IDX_W = (NKEYS > 1) ? $clog2(NKEYS) : 1,
    localparam int CID_W = (NUM_COMBO > 1) ? $clog2(NUM_COMBO) : 1,
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       ev_toggle,
    input  logic                       ev_pressed,
    input  logic                       ev_is_combo,
    input  logic [IDX_W-1:0]           ev_idx,
    input  logic [CID_W-1:0]           ev_combo,
    input  logic [NUM_COMBO*IDX_W-1:0] combo_mod,
    input  logic [NUM_COMBO*IDX_W-1:0] combo_main,
    input  logic [NKEYS-1:0]           ext_matrix,
    input  logic [RW-1:0]              row_sel,
    output logic [COLS-1:0]            col_out,
    output logic [NKEYS-1:0]           matrix,
    output logic [NUM_COMBO-1:0]       combo_busy,
    output logic [2*NUM_COMBO-1:0]     combo_state
);

    localparam int PW = $clog2(PRESCALE);
    localparam logic [7:0] LEAD_LAST = 8'(LEAD_TICKS - 1);
    localparam logic [7:0] MIN_C     = 8'(MIN_HOLD);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LEAD   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;
    localparam logic [1:0] ST_TAIL   = 2'd3;

    // Event handshake: the producer flips ev_toggle exactly once per event and holds the
    // ev_* payload stable around that flip; each observed flip is one event, consumed in
    // the clk that sees it. There is no back-pressure.
    logic             prev_q;
    logic             armed_q;
    logic             ev_fire;
    logic [PW-1:0]    presc_q, presc_d;
    logic             tick;
    logic [NKEYS-1:0] plain_q, plain_d;
    logic [NKEYS-1:0] combo_bits;
    logic [COLS-1:0]  col_d;

    logic [1:0]           st_q  [NUM_COMBO];
    logic [1:0]           st_d  [NUM_COMBO];
    logic [7:0]           cnt_q [NUM_COMBO];
    logic [7:0]           cnt_d [NUM_COMBO];
    logic [NUM_COMBO-1:0] rel_q, rel_d;

    assign ev_fire = armed_q && (ev_toggle != prev_q);
    assign tick    = (32'(presc_q) == PRESCALE - 1);
    assign presc_d = tick ? '0 : presc_q + 1'b1;

    always_comb begin
        plain_d = plain_q;
        if (ev_fire && !ev_is_combo) begin
            for (int k = 0; k < NKEYS; k++) begin
                if (32'(ev_idx) == k) plain_d[k] = ev_pressed;
            end
        end
    end

    // Per channel the event is applied first, then a same-cycle tick acts on the result.
    always_comb begin
        for (int c = 0; c < NUM_COMBO; c++) begin
            st_d[c]  = st_q[c];
            cnt_d[c] = cnt_q[c];
            rel_d[c] = rel_q[c];
            if (ev_fire && ev_is_combo && (32'(ev_combo) == c)) begin
                case (st_q[c])
                    ST_IDLE: begin
                        if (ev_pressed) begin
                            st_d[c]  = ST_LEAD;
                            cnt_d[c] = '0;
                            rel_d[c] = 1'b0;
                        end
                    end
                    ST_LEAD:   rel_d[c] = !ev_pressed;
                    ST_ACTIVE: begin
                        if (!ev_pressed) st_d[c] = (cnt_q[c] >= MIN_C) ? ST_IDLE : ST_TAIL;
                    end
                    default: begin
                        if (ev_pressed) st_d[c] = ST_ACTIVE;
                    end
                endcase
            end
            if (tick) begin
                case (st_d[c])
                    ST_LEAD: begin
                        if (cnt_d[c] == LEAD_LAST) begin
                            // A release seen during the lead resolves on entry; cnt is 0 so it tails.
                            st_d[c]  = rel_d[c] ? ST_TAIL : ST_ACTIVE;
                            cnt_d[c] = '0;
                            rel_d[c] = 1'b0;
                        end else begin
                            cnt_d[c] = cnt_d[c] + 8'd1;
                        end
                    end
                    ST_ACTIVE: begin
                        if (cnt_d[c] < MIN_C) cnt_d[c] = cnt_d[c] + 8'd1;
                    end
                    ST_TAIL: begin
                        if (cnt_d[c] < MIN_C) cnt_d[c] = cnt_d[c] + 8'd1;
                        if (cnt_d[c] >= MIN_C) st_d[c] = ST_IDLE;
                    end
                    default: ;
                endcase
            end
            if (st_d[c] == ST_IDLE) begin
                cnt_d[c] = '0;
                rel_d[c] = 1'b0;
            end
        end
    end

    always_comb begin
        combo_bits = '0;
        for (int c = 0; c < NUM_COMBO; c++) begin
            for (int k = 0; k < NKEYS; k++) begin
                if (st_q[c] != ST_IDLE && 32'(combo_mod[c*IDX_W +: IDX_W]) == k)
                    combo_bits[k] = 1'b1;
                if ((st_q[c] == ST_ACTIVE || st_q[c] == ST_TAIL) &&
                    32'(combo_main[c*IDX_W +: IDX_W]) == k)
                    combo_bits[k] = 1'b1;
            end
        end
    end

    assign matrix = plain_q | ext_matrix | combo_bits;

    always_comb begin
        col_d = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (32'(row_sel) == r) col_d = matrix[r*COLS +: COLS];
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_COMBO; c++) begin
            combo_busy[c]       = (st_q[c] != ST_IDLE);
            combo_state[2*c +: 2] = st_q[c];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            presc_q <= '0;
            plain_q <= '0;
            col_out <= '0;
            rel_q   <= '0;
            for (int c = 0; c < NUM_COMBO; c++) begin
                st_q[c]  <= ST_IDLE;
                cnt_q[c] <= '0;
            end
        end else begin
            prev_q  <= ev_toggle;
            armed_q <= 1'b1;
            presc_q <= presc_d;
            plain_q <= plain_d;
            col_out <= col_d;
            rel_q   <= rel_d;
            for (int c = 0; c < NUM_COMBO; c++) begin
                st_q[c]  <= st_d[c];
                cnt_q[c] <= cnt_d[c];
            end
        end
    end

endmodule

// File: tb/tb_kbd_matrix_combo.sv
// Bench for kbd_matrix_combo: per-cycle scoreboard against a tick/flag reference model,
// plus directed checks of lead latency, minimum hold, overlap and asynchronous reset.
module tb_kbd_matrix_combo;
    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int NC   = 12;
    localparam int P    = 4;
    localparam int LEAD = 3;
    localparam int MINH = 2;
    localparam int NK   = ROWS * COLS;
    localparam int W    = NK + COLS + NC;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            ev_toggle, ev_pressed, ev_is_combo;
    logic [5:0]      ev_idx;
    logic [3:0]      ev_combo;
    logic [NC*6-1:0] combo_mod, combo_main;
    logic [NK-1:0]   ext_matrix;
    logic [2:0]      row_sel;
    logic [COLS-1:0] col_out;
    logic [NK-1:0]   matrix;
    logic [NC-1:0]   combo_busy;
    logic [2*NC-1:0] combo_state;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    // reference model: per channel, key-held flag plus tick counts in lead and main phases
    logic [NK-1:0] m_plain;
    bit   m_on[NC], m_main[NC], m_down[NC];
    int   m_tl[NC], m_tm[NC];
    int   m_k;
    bit   m_armed;
    logic m_prev;
    int   mod_cfg[NC], main_cfg[NC];

    kbd_matrix_combo #(
        .ROWS(ROWS), .COLS(COLS), .NUM_COMBO(NC), .PRESCALE(P),
        .LEAD_TICKS(LEAD), .MIN_HOLD(MINH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ev_toggle(ev_toggle), .ev_pressed(ev_pressed),
        .ev_is_combo(ev_is_combo), .ev_idx(ev_idx), .ev_combo(ev_combo),
        .combo_mod(combo_mod), .combo_main(combo_main), .ext_matrix(ext_matrix),
        .row_sel(row_sel), .col_out(col_out), .matrix(matrix),
        .combo_busy(combo_busy), .combo_state(combo_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [NK-1:0] model_combo();
        logic [NK-1:0] v = '0;
        for (int c = 0; c < NC; c++) begin
            if (m_on[c])   v[mod_cfg[c]]  = 1'b1;
            if (m_main[c]) v[main_cfg[c]] = 1'b1;
        end
        return v;
    endfunction

    task automatic model_reset();
        m_plain = '0; m_k = 0; m_armed = 0; m_prev = 1'b0;
        for (int c = 0; c < NC; c++) begin
            m_on[c] = 0; m_main[c] = 0; m_down[c] = 0; m_tl[c] = 0; m_tm[c] = 0;
        end
    endtask

    task automatic model_step();
        logic [NK-1:0]   pre;
        logic [COLS-1:0] col;
        logic [NC-1:0]   busy;
        bit tk, ev;
        int c, rs;
        if (!reset_n) begin
            model_reset();
            exp_q.push_back('0);
            return;
        end
        pre = m_plain | ext_matrix | model_combo();
        rs  = int'(row_sel);
        col = (rs < ROWS) ? pre[rs*COLS +: COLS] : '0;
        tk  = (m_k % P) == P - 1;
        ev  = m_armed && (ev_toggle != m_prev);
        if (ev) begin
            if (!ev_is_combo) begin
                if (int'(ev_idx) < NK) m_plain[ev_idx] = ev_pressed;
            end else if (int'(ev_combo) < NC) begin
                c = int'(ev_combo);
                if (ev_pressed) begin
                    if (!m_on[c]) begin m_on[c] = 1; m_main[c] = 0; m_tl[c] = 0; end
                    m_down[c] = 1;
                end else if (m_on[c]) begin
                    m_down[c] = 0;
                    if (m_main[c] && m_tm[c] >= MINH) begin m_on[c] = 0; m_main[c] = 0; end
                end
            end
        end
        if (tk) begin
            for (int i = 0; i < NC; i++) begin
                if (m_on[i] && !m_main[i]) begin
                    m_tl[i]++;
                    if (m_tl[i] == LEAD) begin m_main[i] = 1; m_tm[i] = 0; end
                end else if (m_on[i]) begin
                    m_tm[i]++;
                    if (!m_down[i] && m_tm[i] >= MINH) begin m_on[i] = 0; m_main[i] = 0; end
                end
            end
        end
        m_armed = 1; m_prev = ev_toggle; m_k++;
        for (int i = 0; i < NC; i++) busy[i] = m_on[i];
        exp_q.push_back({m_plain | model_combo(), col, busy});
    endtask

    task automatic reset_fall();
        model_reset();
        if (exp_q.size() > 0) begin
            void'(exp_q.pop_back());
            exp_q.push_back('0);
        end
    endtask

    task automatic monitor_step();
        logic [W-1:0] e;
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        chk("sb_matrix", matrix, e[W-1 -: NK] | ext_matrix);
        chk("sb_col_out", 64'(col_out), 64'(e[NC +: COLS]));
        chk("sb_combo_busy", 64'(combo_busy), 64'(e[NC-1:0]));
    endtask

    always @(posedge clk) model_step();
    always @(negedge reset_n) reset_fall();
    always @(negedge clk) monitor_step();

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send(input bit is_c, input bit pr, input int idx, input int cid);
        ev_is_combo = is_c;
        ev_pressed  = pr;
        ev_idx      = 6'(idx);
        ev_combo    = 4'(cid);
        ev_toggle   = ~ev_toggle;
        step(1);
    endtask

    task automatic wait_main9(output int n);
        n = 0;
        while (!matrix[9] && n < 40) begin step(1); n++; end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, r, cid;
        reset_n = 1'b0; ev_toggle = 1'b1; ev_pressed = 1'b0; ev_is_combo = 1'b0;
        ev_idx = '0; ev_combo = '0; ext_matrix = '0; row_sel = '0;
        mod_cfg[0] = 56; main_cfg[0] = 9;
        for (int c = 1; c < NC; c++) begin
            mod_cfg[c]  = $urandom_range(0, NK - 1);
            main_cfg[c] = $urandom_range(0, NK - 1);
        end
        for (int c = 0; c < NC; c++) begin
            combo_mod[c*6 +: 6]  = 6'(mod_cfg[c]);
            combo_main[c*6 +: 6] = 6'(main_cfg[c]);
        end
        step(3);
        reset_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("reset_exit_quiet", matrix, 64'h0);
            chk("reset_exit_busy", 64'(combo_busy), 64'h0);
        end
        step(1);

        // plain key 36 = row 4, col 4
        row_sel = 3'd4;
        send(0, 1, 36, 0);
        @(negedge clk); chk("plain_press_bit36", 64'(matrix[36]), 64'h1);
        step(1);
        @(negedge clk); chk("plain_col_out_row4", 64'(col_out), 64'h10);
        step(1);
        send(0, 0, 36, 0);
        @(negedge clk); chk("plain_release_bit36", 64'(matrix[36]), 64'h0);
        step(2);

        // combo held: mod immediately, main after three ticks, both drop on release
        send(1, 1, 0, 0);
        @(negedge clk);
        chk("combo_mod_immediate", 64'(matrix[56]), 64'h1);
        chk("combo_main_not_yet", 64'(matrix[9]), 64'h0);
        step(0);
        wait_main9(n);
        chk("combo_lead_latency_in_range", 64'(n >= (LEAD - 1) * P && n <= LEAD * P), 64'h1);
        step(10);
        send(1, 0, 0, 0);
        @(negedge clk);
        chk("combo_release_mod", 64'(matrix[56]), 64'h0);
        chk("combo_release_main", 64'(matrix[9]), 64'h0);
        chk("combo_release_busy", 64'(combo_busy[0]), 64'h0);
        step(2);

        // short tap: release during lead, main still held for MIN_HOLD ticks
        send(1, 1, 0, 0);
        step(P);
        send(1, 0, 0, 0);
        chk("tap_mod_in_lead", 64'(matrix[56]), 64'h1);
        wait_main9(n);
        chk("tap_main_seen", 64'(n < 40), 64'h1);
        n = 0;
        while (matrix[9] && n < 40) begin
            if (!matrix[56]) chk("tap_mod_with_main", 64'(matrix[56]), 64'h1);
            n++; step(1);
        end
        chk("tap_main_hold_cycles", 64'(n), 64'(MINH * P));
        chk("tap_mod_drops_with_main", 64'(matrix[56]), 64'h0);
        step(2);

        // overlap: plain 56 and external 9 survive the combo release
        send(1, 1, 0, 0);
        step(22);
        send(0, 1, 56, 0);
        ext_matrix = 64'h200;
        send(1, 0, 0, 0);
        @(negedge clk);
        chk("overlap_bit56", 64'(matrix[56]), 64'h1);
        chk("overlap_bit9", 64'(matrix[9]), 64'h1);
        chk("overlap_busy", 64'(combo_busy[0]), 64'h0);
        step(1);
        send(0, 0, 56, 0);
        ext_matrix = '0;
        step(2);

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(0, 19);
            if (r < 8) begin
                cid = ($urandom_range(0, 7) == 0) ? $urandom_range(12, 15) : $urandom_range(0, 3);
                send(1, 1'($urandom_range(0, 1)), 0, cid);
            end else if (r < 12) begin
                send(0, 1'($urandom_range(0, 1)), $urandom_range(0, NK - 1), 0);
            end else if (r < 14) begin
                ext_matrix = ($urandom_range(0, 2) == 0) ? '0 : (64'h1 << $urandom_range(0, NK - 1));
                step(1);
            end else if (r < 16) begin
                row_sel = 3'($urandom_range(0, ROWS - 1));
                step(1);
            end else if (r < 19) begin
                step($urandom_range(1, 10));
            end else if ($urandom_range(0, 9) == 0) begin
                reset_n = 1'b0;
                step($urandom_range(1, 3));
                reset_n = 1'b1;
                step(1);
            end else begin
                step(1);
            end
        end

        // reset in the tail phase
        reset_n = 1'b0; step(2); reset_n = 1'b1; step(2);
        ext_matrix = 64'h8;
        row_sel = 3'd1;
        send(1, 1, 0, 0);
        wait_main9(n);
        send(1, 0, 0, 0);
        step(1);
        chk("tail_before_reset_main", 64'(matrix[9]), 64'h1);
        reset_n = 1'b0;
        #1;
        chk("tail_reset_matrix", matrix, 64'h8);
        chk("tail_reset_col_out", 64'(col_out), 64'h0);
        chk("tail_reset_busy", 64'(combo_busy), 64'h0);
        step(2);
        reset_n = 1'b1;
        step(2);
        send(1, 1, 0, 0);
        @(negedge clk);
        chk("restart_lead_mod", 64'(matrix[56]), 64'h1);
        chk("restart_lead_main", 64'(matrix[9]), 64'h0);
        step(30);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
